scoreboard_fu: RTL and testbench
================================

Name: scoreboard_fu

Overview:
- Parametrised, multi-cycle integer functional unit for the scoreboard MIPS core.
- Succeeds the combinational ALU:
  - accepts one instruction through an issue handshake;
  - computes over a configurable LATENCY;
  - holds the result until the scoreboard acknowledges write-back.
- Adds logic ops, signed slt, flush, an illegal-op flag, destination-register tagging and parametrised widths.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- ADDR_W, 10, width of mem_dest (data-memory address/register field).
- LATENCY, 2, cycles from issue accept to result_valid; legal range 1..15.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  scoreboard presents an instruction.
- ready  output  1  unit idle; issue accepted on an edge where issue_valid && ready.
- IR  input  32  instruction word (MIPS encoding).
- in_1  input  WIDTH  rs operand.
- in_2  input  WIDTH  rt operand.
- in_immediate  input  WIDTH  sign-extended immediate.
- flush  input  1  abort any in-flight op.
- wb_ack  input  1  scoreboard has consumed the result.
- result_valid  output  1  result/mem_dest/dest_tag/illegal are valid.
- result  output  WIDTH  computed value.
- mem_dest  output  ADDR_W  memory/register destination per op table.
- dest_tag  output  5  architectural destination register.
- illegal  output  1  unsupported opcode/funct.

Behaviour:
- Reset: state IDLE, counter 0; ready=1; result_valid=0; result=0; mem_dest=0; dest_tag=0; illegal=0. Reset overrides all inputs, including mid-EXEC and DONE.
- States:
  - IDLE (ready=1)
  - EXEC (counting)
  - DONE (result_valid=1)
- IDLE -> EXEC on an edge with issue_valid=1 and flush=0.
  - IR and operands are captured at this edge.
  - The op is decoded and computed into internal holding registers.
  - Counter loads LATENCY-1.
- EXEC:
  - If counter==0, go to DONE on the next edge; otherwise decrement.
  - result_valid therefore rises exactly LATENCY cycles after the accept edge. LATENCY=1 means valid on the cycle immediately after accept.
- DONE:
  - Outputs hold stable until an edge with wb_ack=1, then go to IDLE; ready is 1 the following cycle.
  - wb_ack in IDLE or EXEC is ignored.
- flush=1 at any edge: go to IDLE, drop result_valid, discard captured op. Priority order: reset > flush > wb_ack > issue.
- Issue inputs are ignored while ready=0; no queuing.
- When result_valid=0, result, mem_dest, dest_tag and illegal read 0.
- Op table (opcode IR[31:26], funct IR[5:0]); all arithmetic is modulo 2^WIDTH with carry discarded:
  - 000000/100000 add: result=in_1+in_2; dest_tag=IR[15:11]; mem_dest=0.
  - 000000/100010 sub: result=in_1-in_2; dest_tag=IR[15:11]; mem_dest=0.
  - 000000/100100 and: result=in_1&in_2; dest_tag=IR[15:11].
  - 000000/100101 or: result=in_1|in_2; dest_tag=IR[15:11].
  - 000000/101010 slt: result=1 if signed(in_1)<signed(in_2), else 0; dest_tag=IR[15:11].
  - 001000 addi: result=in_1+in_immediate; dest_tag=IR[20:16]; mem_dest=0.
  - 100011 lw: result=in_1+in_immediate (address); mem_dest=IR[20:16] zero-extended to ADDR_W; dest_tag=IR[20:16].
  - 101011 sw: mem_dest=(in_1+in_immediate)[ADDR_W-1:0]; result=in_2; dest_tag=0.
  - Anything else, including unknown funct under opcode 000000: result=0, mem_dest=0, dest_tag=0, illegal=1. The op still completes after LATENCY cycles and still requires wb_ack.
- Simultaneous events:
  - Issue is never accepted in the same edge as wb_ack, because ready=0 in DONE.
  - Flush together with issue_valid in IDLE: issue is not accepted.

Test Plan:
- Reset, LATENCY=2, then issue add (IR=0x00221820, in_1=5, in_2=7) -> ready drops the next cycle; result_valid rises 2 cycles after accept with result=12, dest_tag=3, mem_dest=0. Hold wb_ack=0 for 3 cycles -> outputs stable. Assert wb_ack -> ready=1 the next cycle.
- sub overflow and slt sign: sub in_1=0, in_2=1 -> result=0xFFFFFFFF. slt in_1=0xFFFFFFFF, in_2=1 -> result=1. slt in_1=1, in_2=0xFFFFFFFF -> result=0.
- Memory ops: lw IR=0x8C450004, in_1=0x100, imm=4 -> result=0x104, mem_dest=5, dest_tag=5. sw IR=0xAC450008, in_1=0x3FC, imm=8, in_2=0xABCD -> mem_dest=0x004 (10-bit wrap), result=0xABCD.
- Flush/reset mid-op: issue addi, then assert flush on the cycle after accept -> result_valid never rises; ready=1 the next cycle. Repeat with reset asserted in DONE -> all outputs 0, ready=1.
- Illegal and latency sweep: IR=0xFC000000 -> illegal=1, result=0 after LATENCY cycles. Rerun the add scenario with LATENCY=1 and LATENCY=15 -> valid exactly 1 and 15 cycles after accept. issue_valid held high during EXEC -> no second accept.

Source files
------------

// File: rtl/scoreboard_fu_if.sv
// Issue / write-back bundle between the scoreboard and the integer functional unit.
// master = scoreboard side, slave = functional unit side.
interface scoreboard_fu_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
);
    logic              issue_valid;
    logic              ready;
    logic [31:0]       IR;
    logic [WIDTH-1:0]  in_1;
    logic [WIDTH-1:0]  in_2;
    logic [WIDTH-1:0]  in_immediate;
    logic              flush;
    logic              wb_ack;
    logic              result_valid;
    logic [WIDTH-1:0]  result;
    logic [ADDR_W-1:0] mem_dest;
    logic [4:0]        dest_tag;
    logic              illegal;

    modport master (
        output issue_valid, IR, in_1, in_2, in_immediate, flush, wb_ack,
        input  ready, result_valid, result, mem_dest, dest_tag, illegal
    );

    modport slave (
        input  issue_valid, IR, in_1, in_2, in_immediate, flush, wb_ack,
        output ready, result_valid, result, mem_dest, dest_tag, illegal
    );
endinterface

// File: rtl/scoreboard_fu.sv
// Multi-cycle integer functional unit: decodes and computes at issue, releases the
// result after LATENCY cycles and holds it until the scoreboard acknowledges write-back.
module scoreboard_fu #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic           clock,
    input  logic           reset,
    scoreboard_fu_if.slave bus
);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [3:0]               cnt;
    logic                     accept;

    logic [5:0]               opcode;
    logic [5:0]               funct;
    logic [WIDTH-1:0]         sum_imm;
    logic signed [WIDTH-1:0]  a_s;
    logic signed [WIDTH-1:0]  b_s;
    logic [WIDTH-1:0]         calc_res;
    logic [ADDR_W-1:0]        calc_mem;
    logic [4:0]               calc_tag;
    logic                     calc_ill;
    logic                     unused_ir;

    logic [WIDTH-1:0]         res_p0;
    logic [ADDR_W-1:0]        mem_p0;
    logic [4:0]               tag_p0;
    logic                     ill_p0;

    assign accept    = (state == IDLE) && bus.issue_valid && !bus.flush;
    assign opcode    = bus.IR[31:26];
    assign funct     = bus.IR[5:0];
    assign sum_imm   = bus.in_1 + bus.in_immediate;
    assign a_s       = bus.in_1;
    assign b_s       = bus.in_2;
    assign unused_ir = ^{bus.IR[25:21], bus.IR[10:6]};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset)                        cnt <= '0;
        else if (accept)                  cnt <= CNT_LOAD;
        else if (state == EXEC && cnt != '0) cnt <= cnt - 4'd1;
    end

    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.issue_valid) state_next = EXEC;
                EXEC:    if (cnt == '0)       state_next = DONE;
                DONE:    if (bus.wb_ack)      state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Decode/compute at issue; the result is parked until the latency expires.
    always_comb begin
        calc_res = '0;
        calc_mem = '0;
        calc_tag = '0;
        calc_ill = 1'b0;
        case (opcode)
            6'b000000: begin
                calc_tag = bus.IR[15:11];
                case (funct)
                    6'b100000: calc_res = bus.in_1 + bus.in_2;
                    6'b100010: calc_res = bus.in_1 - bus.in_2;
                    6'b100100: calc_res = bus.in_1 & bus.in_2;
                    6'b100101: calc_res = bus.in_1 | bus.in_2;
                    6'b101010: calc_res = (a_s < b_s) ? WIDTH'(1) : '0;
                    default: begin
                        calc_tag = '0;
                        calc_ill = 1'b1;
                    end
                endcase
            end
            6'b001000: begin
                calc_res = sum_imm;
                calc_tag = bus.IR[20:16];
            end
            6'b100011: begin
                calc_res = sum_imm;
                calc_mem = ADDR_W'(bus.IR[20:16]);
                calc_tag = bus.IR[20:16];
            end
            6'b101011: begin
                calc_res = bus.in_2;
                calc_mem = sum_imm[ADDR_W-1:0];
            end
            default: calc_ill = 1'b1;
        endcase
    end

    // Stage p0: holding registers, loaded only on accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            res_p0 <= calc_res;
            mem_p0 <= calc_mem;
            tag_p0 <= calc_tag;
            ill_p0 <= calc_ill;
        end
    end

    always_comb begin
        bus.ready        = (state == IDLE);
        bus.result_valid = (state == DONE);
        bus.result       = bus.result_valid ? res_p0 : '0;
        bus.mem_dest     = bus.result_valid ? mem_p0 : '0;
        bus.dest_tag     = bus.result_valid ? tag_p0 : '0;
        bus.illegal      = bus.result_valid && ill_p0;
    end
endmodule

// File: tb/tb_scoreboard_fu.sv
// Bench for scoreboard_fu: three instances (LATENCY 1, 2, 15) share one stimulus stream
// and are each compared every cycle against a transaction-level reference model.
module tb_scoreboard_fu;
    typedef struct packed {
        logic [31:0] res;
        logic [9:0]  mem;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        flush;
    logic        wb_ack;
    logic [31:0] ir_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] imm_in;

    logic        o_ready [3];
    logic        o_valid [3];
    logic [31:0] o_res   [3];
    logic [9:0]  o_mem   [3];
    logic [4:0]  o_tag   [3];
    logic        o_ill   [3];

    int checks = 0;
    int errors = 0;

    bit   m_busy [3];
    int   m_age  [3];
    exp_t m_exp  [3];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        scoreboard_fu_if #(.WIDTH(32), .ADDR_W(10)) bus ();
        assign bus.issue_valid  = issue_valid;
        assign bus.IR           = ir_in;
        assign bus.in_1         = a_in;
        assign bus.in_2         = b_in;
        assign bus.in_immediate = imm_in;
        assign bus.flush        = flush;
        assign bus.wb_ack       = wb_ack;
        scoreboard_fu #(
            .WIDTH(32), .ADDR_W(10), .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 15))
        ) u_dut (
            .clock(clock),
            .reset(reset),
            .bus  (bus)
        );
        assign o_ready[g] = bus.ready;
        assign o_valid[g] = bus.result_valid;
        assign o_res[g]   = bus.result;
        assign o_mem[g]   = bus.mem_dest;
        assign o_tag[g]   = bus.dest_tag;
        assign o_ill[g]   = bus.illegal;
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 15);
    endfunction

    // Op table as the scoreboard documents it, in plain arithmetic.
    function automatic exp_t ref_op(input logic [31:0] ir, a, b, imm);
        exp_t        e;
        logic [31:0] addr;
        e    = '0;
        addr = a + imm;
        if (ir[31:26] == 6'h00) begin
            case (ir[5:0])
                6'h20:   begin e.res = a + b; e.tag = ir[15:11]; end
                6'h22:   begin e.res = a - b; e.tag = ir[15:11]; end
                6'h24:   begin e.res = a & b; e.tag = ir[15:11]; end
                6'h25:   begin e.res = a | b; e.tag = ir[15:11]; end
                6'h2A:   begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.tag = ir[15:11]; end
                default: e.ill = 1'b1;
            endcase
        end else if (ir[31:26] == 6'h08) begin
            e.res = addr; e.tag = ir[20:16];
        end else if (ir[31:26] == 6'h23) begin
            e.res = addr; e.mem = {5'd0, ir[20:16]}; e.tag = ir[20:16];
        end else if (ir[31:26] == 6'h2B) begin
            e.res = b; e.mem = addr[9:0];
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            if (reset)               m_busy[i] = 1'b0;
            else if (flush)          m_busy[i] = 1'b0;
            else if (m_busy[i]) begin
                if (m_age[i] >= lat_of(i) && wb_ack) m_busy[i] = 1'b0;
                else if (m_age[i] < lat_of(i))       m_age[i]++;
            end else if (issue_valid) begin
                m_busy[i] = 1'b1;
                m_age[i]  = 0;
                m_exp[i]  = ref_op(ir_in, a_in, b_in, imm_in);
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            bit   v;
            exp_t e;
            v = m_busy[i] && (m_age[i] >= lat_of(i));
            e = v ? m_exp[i] : '0;
            check_val($sformatf("u%0d.ready", i), o_ready[i], !m_busy[i]);
            check_val($sformatf("u%0d.valid", i), o_valid[i], v);
            check_val($sformatf("u%0d.result", i), o_res[i], e.res);
            check_val($sformatf("u%0d.mem_dest", i), o_mem[i], e.mem);
            check_val($sformatf("u%0d.dest_tag", i), o_tag[i], e.tag);
            check_val($sformatf("u%0d.illegal", i), o_ill[i], e.ill);
        end
    endtask

    task automatic set_op(input logic [31:0] ir, a, b, imm);
        ir_in = ir; a_in = a; b_in = b; imm_in = imm;
    endtask

    task automatic run_op(input logic [31:0] ir, a, b, imm,
                          input logic [31:0] e_res, input logic [9:0] e_mem,
                          input logic [4:0] e_tag, input logic e_ill, input bit hold_issue);
        int cyc;
        bit seen [3];
        bit all_seen;
        set_op(ir, a, b, imm);
        issue_valid = 1'b1; flush = 1'b0; wb_ack = 1'b0;
        step();
        if (!hold_issue) issue_valid = 1'b0;
        seen     = '{default: 1'b0};
        all_seen = 1'b0;
        cyc      = 0;
        while (!all_seen && cyc < 20) begin
            step();
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (o_valid[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    check_val($sformatf("u%0d.latency", i), cyc, lat_of(i));
                    check_val($sformatf("u%0d.d_result", i), o_res[i], e_res);
                    check_val($sformatf("u%0d.d_mem_dest", i), o_mem[i], e_mem);
                    check_val($sformatf("u%0d.d_dest_tag", i), o_tag[i], e_tag);
                    check_val($sformatf("u%0d.d_illegal", i), o_ill[i], e_ill);
                end
            end
            all_seen = seen[0] && seen[1] && seen[2];
        end
        if (!all_seen) check_val("valid_timeout", 0, 1);
        repeat (3) step();
        issue_valid = 1'b0;
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        step();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [4:0]  rs, rt, rd;
        logic [15:0] im;
        logic [5:0]  fn;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); im = 16'($urandom);
        case ($urandom_range(0, 4))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; default: fn = 6'h2A;
        endcase
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return {6'h00, rs, rt, rd, 5'd0, fn};
            5:             return {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
            6:             return {6'h08, rs, rt, im};
            7:             return {6'h23, rs, rt, im};
            8:             return {6'h2B, rs, rt, im};
            default:       return $urandom;
        endcase
    endfunction

    initial begin
        int waited;
        reset = 1'b1; issue_valid = 1'b0; flush = 1'b0; wb_ack = 1'b0;
        set_op(32'd0, 32'd0, 32'd0, 32'd0);
        m_busy = '{default: 1'b0};
        m_age  = '{default: 0};
        m_exp  = '{default: '0};
        step();
        step();
        reset = 1'b0;
        step();

        run_op(32'h0022_1820, 32'd5, 32'd7, 32'd0, 32'd12, 10'd0, 5'd3, 1'b0, 1'b0);
        run_op(32'h0022_1822, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 10'd0, 5'd3, 1'b0, 1'b0);
        run_op(32'h0022_182A, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 10'd0, 5'd3, 1'b0, 1'b0);
        run_op(32'h0022_182A, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 10'd0, 5'd3, 1'b0, 1'b0);
        run_op(32'h8C45_0004, 32'h100, 32'd0, 32'd4, 32'h104, 10'd5, 5'd5, 1'b0, 1'b0);
        run_op(32'hAC45_0008, 32'h3FC, 32'hABCD, 32'd8, 32'hABCD, 10'h004, 5'd0, 1'b0, 1'b0);
        run_op(32'hFC00_0000, 32'd9, 32'd9, 32'd9, 32'd0, 10'd0, 5'd0, 1'b1, 1'b0);
        run_op(32'h0022_1820, 32'd5, 32'd7, 32'd0, 32'd12, 10'd0, 5'd3, 1'b0, 1'b1);

        // Flush on the cycle after accept.
        set_op(32'h2045_0003, 32'd10, 32'd0, 32'd3);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (18) step();

        // Flush together with issue in IDLE.
        issue_valid = 1'b1; flush = 1'b1;
        step();
        issue_valid = 1'b0; flush = 1'b0;
        repeat (3) step();

        // Reset while all instances sit in DONE.
        set_op(32'h0022_1820, 32'd5, 32'd7, 32'd0);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        waited = 0;
        while (!(o_valid[0] && o_valid[1] && o_valid[2]) && waited < 20) begin
            step();
            waited++;
        end
        check_val("done_before_reset", o_valid[0] && o_valid[1] && o_valid[2], 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        for (int n = 0; n < 1500; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 99) < 3);
            issue_valid = ($urandom_range(0, 99) < 40);
            wb_ack      = ($urandom_range(0, 99) < 25);
            ir_in       = rand_ir();
            a_in        = rand_operand();
            b_in        = rand_operand();
            imm_in      = {{16{ir_in[15]}}, ir_in[15:0]};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
